// File: rtl/sub_seq6_pkg.sv
// Shared constants, FSM state type and slice-count helper for the sliced subtractor.
package sub_seq6_pkg;

    localparam int SLICE_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/sub_seq6_slice6.sv
// Combinational 6-bit lookahead slice computing a + ~b + c_in.
// Bits 0..3 form one lookahead group; bits 4..5 look ahead from that group's carry.
module sub_slice6
    import sub_seq6_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c_in,
    output logic [SLICE_W-1:0] sum,
    output logic               c_out
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;
    logic               grp_g;
    logic               grp_p;

    always_comb begin
        g = a & ~b;
        p = a ^ ~b;

        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p[3:0];

        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
        c[4] = grp_g | (grp_p & c_in);
        c[5] = g[4] | (p[4] & c[4]);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);

        sum   = p ^ c[SLICE_W-1:0];
        c_out = c[SLICE_W];
    end

endmodule

// File: rtl/sub_seq6.sv
// Multi-cycle subtractor: in_A - in_B - b_in, one 6-bit slice per clock, LSB slice first.
// Latency NSLICE+1 edges from accepted start to done; start is ignored while busy.
module sub_seq6
    import sub_seq6_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int NSLICE = calc_nslice(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             b_in,
    output logic [WIDTH-1:0] out,
    output logic             b_out,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               b_out_q, b_out_d;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] sum_sl;
    logic               c_sl;
    logic               last_slice;
    logic               accept;

    assign a_sl       = a_q[idx_q*SLICE_W +: SLICE_W];
    assign b_sl       = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));
    assign accept     = start && (state_q != RUN);

    sub_slice6 u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .c_in  (c_q),
        .sum   (sum_sl),
        .c_out (c_sl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Carry register holds the add-of-complement carry; borrow is its inverse.
    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        out_d   = out_q;
        b_out_d = b_out_q;
        if (accept) begin
            a_d   = in_A;
            b_d   = in_B;
            c_d   = ~b_in;
            idx_d = '0;
        end else if (state_q == RUN) begin
            out_d[idx_q*SLICE_W +: SLICE_W] = sum_sl;
            c_d = c_sl;
            if (last_slice) begin
                idx_d   = '0;
                b_out_d = ~c_sl;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            out_q   <= '0;
            b_out_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            out_q   <= out_d;
            b_out_q <= b_out_d;
        end
    end

    assign out   = out_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_sub_seq6.sv
// Scoreboard bench for sub_seq6: driver pushes reference results, monitor checks on done.
module tb_sub_seq6;

    localparam int WIDTH  = 24;
    localparam int NSLICE = WIDTH / 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             b_in;
    logic [WIDTH-1:0] out;
    logic             b_out;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             bo;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   next_free = 0;
    int   tests     = 0;
    int   fails     = 0;

    sub_seq6 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_A  (in_A),
        .in_B  (in_B),
        .b_in  (b_in),
        .out   (out),
        .b_out (b_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: plain integer subtraction modulo 2^WIDTH, borrow from unsigned compare.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bi, input int acc);
        exp_t e;
        logic [WIDTH:0] wa, wb;
        wa    = {1'b0, a};
        wb    = {1'b0, b} + (WIDTH+1)'(bi);
        e.res = WIDTH'(wa - wb);
        e.bo  = (wa < wb);
        e.acc = acc;
        return e;
    endfunction

    // mode 0: start low while waiting; 1: start held high; 2: random start pulses during RUN.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bi, input int gap, input int mode);
        while (cyc < next_free + gap) begin
            if (cyc < next_free && mode != 0) begin
                start = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                in_A  = WIDTH'($urandom);
                in_B  = WIDTH'($urandom);
                b_in  = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b1;
        in_A  = a;
        in_B  = b;
        b_in  = bi;
        sb.push_back(model(a, b, bi, cyc + 1));
        next_free = cyc + 1 + NSLICE;
        @(posedge clk); #1;
        start = (mode == 1);
        in_A  = WIDTH'($urandom);
        in_B  = WIDTH'($urandom);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].acc + NSLICE);
        check("busy", 32'(busy), 32'(exp_busy));
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out", 32'(out), 32'(e.res));
                check("b_out", 32'(b_out), 32'(e.bo));
                check("done_cycle", 32'(cyc), 32'(e.acc + NSLICE));
            end
        end else if (sb.size() > 0 && cyc >= sb[0].acc + NSLICE) begin
            e = sb.pop_front();
            check("missed_done", 32'(done), 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int mode;
        logic [WIDTH-1:0] a, b;
        rst   = 1'b0;
        start = 1'b0;
        in_A  = '0;
        in_B  = '0;
        b_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        next_free = cyc;

        issue(24'h00000A, 24'h000003, 1'b0, 0, 0);
        issue(24'h000000, 24'h000001, 1'b0, 2, 0);
        issue(24'h000040, 24'h000001, 1'b0, 1, 0);
        issue(24'h123456, 24'h123456, 1'b1, 0, 0);
        issue(24'h000100, 24'h000001, 1'b0, 0, 2);
        issue(24'hFFFFFF, 24'h000000, 1'b1, 0, 1);
        for (int i = 0; i < 4; i++)
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 0, 1);
        issue(24'h000001, 24'hFFFFFF, 1'b0, 0, 0);

        // Reset during RUN once two slices have been computed.
        issue(24'h654321, 24'h012345, 1'b0, 0, 0);
        acc = cyc;
        while (cyc < acc + 2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        sb.delete();
        #1;
        check("abort_out", 32'(out), 32'd0);
        check("abort_b_out", 32'(b_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        next_free = cyc;
        repeat (NSLICE + 3) @(posedge clk);
        #1;
        issue(24'h000010, 24'h000020, 1'b1, 0, 0);

        for (int i = 0; i < 150; i++) begin
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : WIDTH'($urandom);
            mode = $urandom_range(0, 2);
            issue(a, b, 1'($urandom_range(0, 1)), (mode == 1) ? 0 : $urandom_range(0, 2), mode);
        end

        start = 1'b0;
        for (int i = 0; i < 4 * NSLICE && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk); #1;
        if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
